// File: rtl/wave_meter.sv
// Waveform meter: hysteretic rising-crossing detector that reports period, max, min and
// peak-to-peak amplitude of one cycle of an 8-bit sample stream.
module wave_meter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned THRESH     = 128,
  parameter int unsigned HYST       = 8,
  parameter int unsigned MAX_PERIOD = 65535
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sample_en,
  input  logic [WIDTH-1:0] i_wave_in,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_cont,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_period,
  output logic [WIDTH-1:0] o_wmax,
  output logic [WIDTH-1:0] o_wmin,
  output logic [WIDTH-1:0] o_amplitude
);

  localparam logic [WIDTH-1:0] LowLvl = WIDTH'(THRESH - HYST);
  localparam logic [WIDTH-1:0] ThrLvl = WIDTH'(THRESH);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_PERIOD);

  typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_e;

  state_e           r_state, w_state_nxt;
  logic             r_low_seen, w_low_seen_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_max, w_max_nxt;
  logic [WIDTH-1:0] r_min, w_min_nxt;
  logic             r_done, w_done_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic [WIDTH-1:0] r_wmax, w_wmax_nxt;
  logic [WIDTH-1:0] r_wmin, w_wmin_nxt;
  logic [WIDTH-1:0] r_amp, w_amp_nxt;

  logic             w_low;
  logic             w_event;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_max_in;
  logic [WIDTH-1:0] w_min_in;

  assign w_low     = i_sample_en && (i_wave_in < LowLvl);
  assign w_event   = i_sample_en && r_low_seen && (i_wave_in >= ThrLvl);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_max_in  = (i_wave_in > r_max) ? i_wave_in : r_max;
  assign w_min_in  = (i_wave_in < r_min) ? i_wave_in : r_min;

  always_comb begin
    w_state_nxt    = r_state;
    w_low_seen_nxt = r_low_seen;
    w_cnt_nxt      = r_cnt;
    w_max_nxt      = r_max;
    w_min_nxt      = r_min;
    w_done_nxt     = 1'b0;
    w_timeout_nxt  = r_timeout;
    w_period_nxt   = r_period;
    w_wmax_nxt     = r_wmax;
    w_wmin_nxt     = r_wmin;
    w_amp_nxt      = r_amp;

    if (w_low) begin
      w_low_seen_nxt = 1'b1;
    end else if (w_event) begin
      w_low_seen_nxt = 1'b0;
    end

    if (i_stop) begin
      w_state_nxt = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            w_state_nxt    = StArm;
            w_low_seen_nxt = 1'b0;
          end
        end
        StArm: begin
          if (w_event) begin
            w_state_nxt = StMeasure;
            w_cnt_nxt   = '0;
            w_max_nxt   = i_wave_in;
            w_min_nxt   = i_wave_in;
          end
        end
        StMeasure: begin
          if (i_sample_en) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_event) begin
              // Terminating sample closes this cycle and, in continuous mode, opens the next.
              w_period_nxt  = w_cnt_inc;
              w_wmax_nxt    = r_max;
              w_wmin_nxt    = r_min;
              w_amp_nxt     = r_max - r_min;
              w_timeout_nxt = 1'b0;
              w_done_nxt    = 1'b1;
              if (i_cont) begin
                w_cnt_nxt = '0;
                w_max_nxt = i_wave_in;
                w_min_nxt = i_wave_in;
              end else begin
                w_state_nxt = StIdle;
              end
            end else if (w_cnt_inc == MaxCnt) begin
              w_period_nxt  = MaxCnt;
              w_wmax_nxt    = w_max_in;
              w_wmin_nxt    = w_min_in;
              w_amp_nxt     = w_max_in - w_min_in;
              w_timeout_nxt = 1'b1;
              w_done_nxt    = 1'b1;
              w_state_nxt   = StIdle;
            end else begin
              w_max_nxt = w_max_in;
              w_min_nxt = w_min_in;
            end
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_low_seen <= 1'b0;
      r_cnt      <= '0;
      r_max      <= '0;
      r_min      <= '0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_period   <= '0;
      r_wmax     <= '0;
      r_wmin     <= '0;
      r_amp      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_low_seen <= w_low_seen_nxt;
      r_cnt      <= w_cnt_nxt;
      r_max      <= w_max_nxt;
      r_min      <= w_min_nxt;
      r_done     <= w_done_nxt;
      r_timeout  <= w_timeout_nxt;
      r_period   <= w_period_nxt;
      r_wmax     <= w_wmax_nxt;
      r_wmin     <= w_wmin_nxt;
      r_amp      <= w_amp_nxt;
    end
  end

  assign o_busy      = (r_state != StIdle);
  assign o_done      = r_done;
  assign o_timeout   = r_timeout;
  assign o_period    = r_period;
  assign o_wmax      = r_wmax;
  assign o_wmin      = r_wmin;
  assign o_amplitude = r_amp;

endmodule
